// File: rtl/multi_cycle_controller_if.sv
// rtl/multi_cycle_controller_if.sv - control bundle between the multi-cycle controller and its datapath
interface multi_cycle_controller_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_operation;
    logic [1:0] pc_src;
    logic       pc_write;

    modport master (
        input  opcode, func, zero, mem_ready,
        output i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_operation, pc_src, pc_write
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alu_operation, pc_src, pc_write
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - multi-cycle MIPS sequencing FSM; MULTI_CYCLE_CONTROLLER_PERF_CNT_EN adds instr/stall counters
module multi_cycle_controller (
    input  logic                       clk,
    input  logic                       rst,
    multi_cycle_controller_if.master   bus
`ifdef MULTI_CYCLE_CONTROLLER_PERF_CNT_EN
    ,
    output logic [31:0]                instr_count,
    output logic [31:0]                stall_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state;
    state_t     next_state;
    logic [2:0] r_op;
    logic [2:0] i_op;

    // opcode/func are stable from DECODE onward, so the EXEC and WB states share one decode
    always_comb begin
        case (bus.func)
            6'b100000: r_op = ALU_ADD;
            6'b100010: r_op = ALU_SUB;
            6'b100100: r_op = ALU_AND;
            6'b100101: r_op = ALU_OR;
            6'b101010: r_op = ALU_SLT;
            default:   r_op = ALU_ADD;
        endcase
        i_op = (bus.opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state        = state;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_operation = ALU_ADD;
        bus.pc_src        = 2'b00;
        bus.pc_write      = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                if (bus.mem_ready)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_b = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:     next_state = S_MEM_ADDR;
                    OP_RTYPE:         next_state = S_R_EXEC;
                    OP_ADDI, OP_ANDI: next_state = S_I_EXEC;
                    OP_BEQ, OP_BNE:   next_state = S_BRANCH;
                    OP_J:             next_state = S_JUMP;
                    default:          next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
                next_state    = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                bus.i_or_d   = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready)
                    next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = 1'b1;
                next_state     = S_FETCH;
            end
            S_MEM_WRITE: begin
                bus.i_or_d    = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready)
                    next_state = S_FETCH;
            end
            S_R_EXEC: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_operation = r_op;
                next_state        = S_R_WB;
            end
            S_R_WB: begin
                bus.reg_dst       = 1'b1;
                bus.reg_write     = 1'b1;
                bus.alu_operation = r_op;
                next_state        = S_FETCH;
            end
            S_I_EXEC: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_src_b     = 2'b10;
                bus.alu_operation = i_op;
                next_state        = S_I_WB;
            end
            S_I_WB: begin
                bus.reg_write     = 1'b1;
                bus.alu_operation = i_op;
                next_state        = S_FETCH;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_operation = ALU_SUB;
                bus.pc_src        = 2'b01;
                bus.pc_write      = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
                next_state        = S_FETCH;
            end
            S_JUMP: begin
                bus.pc_src   = 2'b10;
                bus.pc_write = 1'b1;
                next_state   = S_FETCH;
            end
            default: next_state = S_FETCH;
        endcase
        // reset masks every strobe so nothing in the datapath is written while it is held
        if (rst) begin
            bus.i_or_d        = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.ir_write      = 1'b0;
            bus.reg_dst       = 1'b0;
            bus.mem_to_reg    = 1'b0;
            bus.reg_write     = 1'b0;
            bus.alu_src_a     = 1'b0;
            bus.alu_src_b     = 2'b00;
            bus.alu_operation = ALU_ADD;
            bus.pc_src        = 2'b00;
            bus.pc_write      = 1'b0;
        end
    end

`ifdef MULTI_CYCLE_CONTROLLER_PERF_CNT_EN
    logic completing;
    logic stalling;

    // FETCH->FETCH is a stall and DECODE->FETCH is the illegal-opcode path; neither retires
    assign completing = (next_state == S_FETCH) && (state != S_FETCH) && (state != S_DECODE);
    assign stalling   = ((state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE))
                        && !bus.mem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (completing)
                instr_count <= instr_count + 32'd1;
            if (stalling)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
